// File: rtl/watchdog_multi.sv
// Multi-source watchdog: counts slow TICK edges between kicks, holds the system in reset
// for a fixed number of ticks after a timeout or external reset, and counts trips.
module watchdog_multi #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned HOLD    = 8,
  parameter int unsigned WARN_AT = 6,
  parameter int unsigned NKICK   = 2,
  parameter int unsigned TRIP_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [NKICK-1:0]  KICK,
  input  logic              TICK,
  input  logic              EXT_nRST,
  output logic              nRESET,
  output logic              nHALT,
  output logic              WARN,
  output logic [TRIP_W-1:0] TRIP_CNT,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    StDisabled = 2'b00,
    StCount    = 2'b01,
    StHold     = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]   hold_q, hold_d, hold_inc;
  logic [TRIP_W-1:0]  trip_q, trip_d;
  logic               tick_d_q;
  logic               warn_q, warn_d;
  logic               tick_edge;

  always_comb begin
    tick_edge = TICK & ~tick_d_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    hold_inc  = hold_q + CNT_W'(1);
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    trip_d    = trip_q;

    if (!EN) begin
      state_d = StDisabled;
      cnt_d   = '0;
      hold_d  = '0;
    end else if (!EXT_nRST) begin
      // External reset parks us in HOLD so the full hold period runs after release.
      state_d = StHold;
      cnt_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        StDisabled: begin
          state_d = StCount;
          cnt_d   = '0;
        end
        StCount: begin
          if (|KICK) begin
            cnt_d = '0;
          end else if (tick_edge) begin
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
              state_d = StHold;
              cnt_d   = '0;
              hold_d  = '0;
              if (trip_q != '1) trip_d = trip_q + TRIP_W'(1);
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StHold: begin
          if (tick_edge) begin
            if (hold_inc == CNT_W'(HOLD)) begin
              state_d = StCount;
              cnt_d   = '0;
              hold_d  = '0;
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        default: begin
          state_d = StCount;
          cnt_d   = '0;
          hold_d  = '0;
        end
      endcase
    end

    // Counter only steps by one from a cleared value, so the transition fires once per clear.
    warn_d = (WARN_AT != 0) && (cnt_d == CNT_W'(WARN_AT)) && (cnt_q != CNT_W'(WARN_AT));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= EN ? StCount : StDisabled;
      cnt_q    <= '0;
      hold_q   <= '0;
      trip_q   <= '0;
      tick_d_q <= 1'b0;
      warn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      trip_q   <= trip_d;
      tick_d_q <= TICK;
      warn_q   <= warn_d;
    end
  end

  assign nRESET   = EXT_nRST & (state_q != StHold);
  assign nHALT    = nRESET;
  assign WARN     = warn_q;
  assign TRIP_CNT = trip_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_watchdog_multi.sv
// Directed bench for watchdog_multi: a default instance and a TRIP_W=2 instance share stimulus
// and are checked every cycle against a tick-counting model.
module tb_watchdog_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] kick = 2'b00;
  logic       tick = 1'b0;
  logic       ext = 1'b1;

  logic       nreset_a, nhalt_a, warn_a;
  logic [7:0] trip_a;
  logic [1:0] state_a;
  logic       nreset_b, nhalt_b, warn_b;
  logic [1:0] trip_b;
  logic [1:0] state_b;

  int n_checks = 0;
  int n_err = 0;

  // Model: plain counts of ticks since last kick and ticks spent holding.
  bit m_on, m_in_hold, m_warn, m_tick_prev;
  int m_ticks, m_hold_ticks, m_trips;

  int low_cycles, warn_cycles;

  always #5 clk = ~clk;

  watchdog_multi dut (
    .CLK(clk), .RST(rst), .EN(en), .KICK(kick), .TICK(tick), .EXT_nRST(ext),
    .nRESET(nreset_a), .nHALT(nhalt_a), .WARN(warn_a), .TRIP_CNT(trip_a), .STATE(state_a)
  );

  watchdog_multi #(.TRIP_W(2)) dut_sat (
    .CLK(clk), .RST(rst), .EN(en), .KICK(kick), .TICK(tick), .EXT_nRST(ext),
    .nRESET(nreset_b), .nHALT(nhalt_b), .WARN(warn_b), .TRIP_CNT(trip_b), .STATE(state_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit edge_now;
    m_warn = 1'b0;
    if (rst) begin
      m_on = en; m_in_hold = 1'b0; m_ticks = 0; m_hold_ticks = 0; m_trips = 0;
      m_tick_prev = 1'b0;
      return;
    end
    edge_now = tick && !m_tick_prev;
    m_tick_prev = tick;
    if (!en) begin
      m_on = 1'b0; m_in_hold = 1'b0; m_ticks = 0; m_hold_ticks = 0;
    end else if (!ext) begin
      m_on = 1'b1; m_in_hold = 1'b1; m_ticks = 0; m_hold_ticks = 0;
    end else if (!m_on) begin
      m_on = 1'b1; m_ticks = 0;
    end else if (m_in_hold) begin
      if (edge_now) begin
        m_hold_ticks++;
        if (m_hold_ticks == 8) begin
          m_in_hold = 1'b0; m_hold_ticks = 0; m_ticks = 0;
        end
      end
    end else if (kick != 2'b00) begin
      m_ticks = 0;
    end else if (edge_now) begin
      m_ticks++;
      if (m_ticks == 6) m_warn = 1'b1;
      if (m_ticks == 8) begin
        m_in_hold = 1'b1; m_ticks = 0; m_hold_ticks = 0; m_trips++;
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare both instances at negedge.
  task automatic cyc(input logic [1:0] k, input logic t);
    int exp_state;
    bit exp_nres;
    kick = k;
    tick = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_state = !m_on ? 0 : (m_in_hold ? 2 : 1);
    exp_nres = ext && !(m_on && m_in_hold);
    chk("state", 32'(state_a), 32'(exp_state));
    chk("nreset", 32'(nreset_a), 32'(exp_nres));
    chk("nhalt", 32'(nhalt_a), 32'(exp_nres));
    chk("warn", 32'(warn_a), 32'(m_warn));
    chk("trip_cnt", 32'(trip_a), 32'((m_trips > 255) ? 255 : m_trips));
    chk("cnt", 32'(dut.cnt_q), 32'(m_ticks));
    chk("sat_state", 32'(state_b), 32'(exp_state));
    chk("sat_nreset", 32'(nreset_b), 32'(exp_nres));
    chk("sat_trip_cnt", 32'(trip_b), 32'((m_trips > 3) ? 3 : m_trips));
    if (!nreset_a) low_cycles++;
    if (warn_a) warn_cycles++;
  endtask

  task automatic tick_edge(input logic [1:0] k);
    cyc(k, 1'b1);
    cyc(2'b00, 1'b0);
  endtask

  task automatic clear_stats();
    low_cycles = 0;
    warn_cycles = 0;
  endtask

  initial begin
    // Reset with EN low lands in DISABLED.
    rst = 1'b1; en = 1'b0; ext = 1'b1;
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b0);
    chk("reset_disabled", 32'(state_a), 32'd0);
    chk("reset_trip", 32'(trip_a), 32'd0);
    rst = 1'b0;
    en = 1'b1;
    cyc(2'b00, 1'b0);
    chk("en_rise_count", 32'(state_a), 32'd1);
    chk("en_rise_cnt0", 32'(dut.cnt_q), 32'd0);

    // Basic trip: 8 edges, then 8 held edges.
    clear_stats();
    for (int i = 0; i < 16; i++) tick_edge(2'b00);
    chk("trip_low_cycles", 32'(low_cycles), 32'd16);
    chk("trip_warn_once", 32'(warn_cycles), 32'd1);
    chk("trip_count_1", 32'(trip_a), 32'd1);
    chk("trip_released", 32'(nreset_a), 32'd1);

    // WARN twice, separated by a kick.
    for (int r = 0; r < 2; r++) begin
      cyc(2'b01, 1'b0);
      clear_stats();
      for (int i = 0; i < 6; i++) tick_edge(2'b00);
      chk("warn_pulse", 32'(warn_cycles), 32'd1);
    end
    cyc(2'b01, 1'b0);

    // Kick coincident with edges 7, 14, 21 prevents any trip.
    clear_stats();
    for (int i = 1; i <= 21; i++) begin
      if (i % 7 == 0) begin
        cyc(2'b10, 1'b1);
        chk("kick_wins_cnt0", 32'(dut.cnt_q), 32'd0);
        cyc(2'b00, 1'b0);
      end else begin
        tick_edge(2'b00);
      end
    end
    chk("kick_no_trip_low", 32'(low_cycles), 32'd0);
    chk("kick_trip_unchanged", 32'(trip_a), 32'd1);

    // External reset for 3 edges, then 8 held edges after release.
    cyc(2'b01, 1'b0);
    clear_stats();
    ext = 1'b0;
    for (int i = 0; i < 3; i++) tick_edge(2'b01);
    ext = 1'b1;
    for (int i = 0; i < 8; i++) tick_edge(2'b00);
    chk("ext_low_cycles", 32'(low_cycles), 32'd20);
    chk("ext_trip_unchanged", 32'(trip_a), 32'd1);

    // Disable mid-HOLD.
    for (int i = 0; i < 10; i++) tick_edge(2'b00);
    chk("pre_disable_hold", 32'(state_a), 32'd2);
    en = 1'b0;
    cyc(2'b00, 1'b0);
    chk("disable_nreset", 32'(nreset_a), 32'd1);
    chk("disable_state", 32'(state_a), 32'd0);
    en = 1'b1;
    cyc(2'b00, 1'b0);
    chk("reenable_state", 32'(state_a), 32'd1);
    chk("reenable_cnt0", 32'(dut.cnt_q), 32'd0);

    // Three more full trips: five in total.
    for (int i = 0; i < 48; i++) tick_edge(2'b00);
    chk("sat_trip_3", 32'(trip_b), 32'd3);
    chk("wide_trip_5", 32'(trip_a), 32'd5);

    // RST during HOLD releases nRESET next cycle.
    for (int i = 0; i < 8; i++) tick_edge(2'b00);
    chk("pre_rst_hold", 32'(nreset_a), 32'd0);
    rst = 1'b1;
    cyc(2'b00, 1'b0);
    chk("rst_hold_nreset", 32'(nreset_a), 32'd1);
    chk("rst_hold_state", 32'(state_a), 32'd1);
    chk("rst_hold_trip0", 32'(trip_a), 32'd0);
    rst = 1'b0;

    // EXT_nRST low while disabled: stays DISABLED, nRESET follows EXT_nRST.
    en = 1'b0;
    ext = 1'b0;
    tick_edge(2'b00);
    chk("ext_dis_state", 32'(state_a), 32'd0);
    chk("ext_dis_nreset", 32'(nreset_a), 32'd0);
    ext = 1'b1;
    cyc(2'b00, 1'b0);
    chk("ext_dis_release", 32'(nreset_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
